eb_skp_ctrl: RTL and testbench
==============================

Name: eb_skp_ctrl

Overview:
- Read-side controller for the RX elastic buffer.
- Watches buffer fill level and the symbol at the read head, then decides the read-pointer advance each cycle.
- Inserts or removes SKP symbols to hold occupancy at a mode-dependent target; sequences initial fill and underflow recovery.
- Sits between the elastic buffer's synchronized fill counter and its read pointer, all in the read clock domain.

Parameters:
- DATA_WIDTH, 10, width of 8b/10b symbol at read head
- BUFFER_DEPTH, 16, buffer entries (power of 2); AW = $clog2(BUFFER_DEPTH) derived locally
- LOW_TARGET, 2, target fill in nominal-empty mode
- HYST, 1, dead band around target before any SKP adjustment
- SKP_RDN, 10'h0F9, SKP symbol, negative disparity
- SKP_RDP, 10'h306, SKP symbol, positive disparity

Ports:
- read_clk  in  1  read-domain clock
- rst_n  in  1  reset
- buffer_mode  in  1  0 = nominal-empty (target LOW_TARGET), 1 = half-full (target BUFFER_DEPTH/2)
- fill_level  in  AW+1  current occupancy, 0..BUFFER_DEPTH
- rd_symbol  in  DATA_WIDTH  symbol at buffer read head
- rd_inc  out  2  read-pointer advance: 0 hold, 1 normal, 2 skip one
- data_valid  out  1  rd_symbol is valid output this cycle
- skp_added  out  1  one-cycle pulse, SKP repeated
- skp_removed  out  1  one-cycle pulse, SKP dropped
- overflow  out  1  one-cycle pulse, fill_level == BUFFER_DEPTH
- underflow  out  1  one-cycle pulse, fill_level == 0 while RUN

Behaviour:
- Single clock read_clk; reset is synchronous, active-low (rst_n sampled on rising read_clk).
- Reset values: state=FILL, os_adj=0, rd_inc=0, data_valid=0, all pulses 0.
- Reset mid-operation: same values on next edge; any adjustment in progress is abandoned.
- TARGET = buffer_mode ? BUFFER_DEPTH/2 : LOW_TARGET, re-evaluated every cycle; a mode change in RUN changes only the thresholds, not the state.
- is_skp = (rd_symbol == SKP_RDN) || (rd_symbol == SKP_RDP).
- Decode: rd_inc, data_valid and all pulses are combinational from the registered state plus current inputs. The state and os_adj registers update on rising read_clk.
- FILL:
  - rd_inc=0, data_valid=0.
  - Go to RUN when fill_level >= TARGET.
- RUN, evaluated in priority order:
  1. fill_level == 0: underflow=1, rd_inc=0, data_valid=0; next state FILL.
  2. fill_level == BUFFER_DEPTH: overflow=1, rd_inc=1, data_valid=1. No SKP adjustment this cycle. The write side drops data.
  3. is_skp && !os_adj && fill_level > TARGET+HYST && fill_level >= 2: rd_inc=2, skp_removed=1, data_valid=1, os_adj<=1.
  4. is_skp && !os_adj && fill_level < TARGET-HYST (signed compare; never true when TARGET <= HYST): rd_inc=0, skp_added=1, data_valid=1. The same SKP is presented again next cycle. os_adj<=1.
  5. Otherwise: rd_inc=1, data_valid=1.
- os_adj limits adjustment to one per ordered set. It clears on any cycle with data_valid && !is_skp.
- The SKP repeated by an insert is not itself eligible for adjustment, because os_adj is already 1.
- overflow and underflow are never asserted in the same cycle. skp_added and skp_removed are mutually exclusive.
- fill_level is trusted as given; values above BUFFER_DEPTH are treated as full.

Optional Feature:
- Macro EB_SKP_STATS_EN.
- Defined:
  - Adds outputs add_cnt[7:0] and rem_cnt[7:0].
  - Each is a saturating (stops at 255) count of skp_added / skp_removed pulses.
  - Both reset to 0 on rst_n=0 and are registered; they increment the cycle after the pulse.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset/fill: rst_n=0 for 2 cycles, release with buffer_mode=0, fill_level ramping 0,1,2 -> rd_inc=0 and data_valid=0 until the cycle fill_level=2, then rd_inc=1 from the following cycle.
- Removal: RUN, buffer_mode=0, fill_level=5, rd_symbol sequence 0x17C, 0x0F9, 0x0F9, 0x0AA -> rd_inc=2 and skp_removed=1 on the first 0x0F9 only; rd_inc=1 on all other cycles.
- Insertion: buffer_mode=1 (TARGET=8), fill_level=5, rd_symbol 0x306 held 2 cycles then 0x2BB -> cycle 1 rd_inc=0, skp_added=1; cycle 2 rd_inc=1, no pulse; os_adj clears on 0x2BB.
- Underflow: RUN, fill_level drops to 0 -> underflow=1 for one cycle, state FILL, rd_inc=0 until fill_level >= TARGET again.
- Overflow with SKP: fill_level=16, rd_symbol=0x0F9 -> overflow=1, rd_inc=1, skp_removed=0.
- Mid-op reset and stats: rst_n=0 during an SKP insert cycle -> next edge all outputs 0, state FILL. With EB_SKP_STATS_EN, 300 removals -> rem_cnt=255.

Source files
------------

// File: rtl/eb_skp_ctrl.sv
// rtl/eb_skp_ctrl.sv - RX elastic buffer read-side SKP insert/remove controller
// Optional EB_SKP_STATS_EN adds saturating add_cnt/rem_cnt statistics outputs.
module eb_skp_ctrl #(
    parameter int DATA_WIDTH               = 10,
    parameter int BUFFER_DEPTH             = 16,
    parameter int LOW_TARGET               = 2,
    parameter int HYST                     = 1,
    parameter logic [DATA_WIDTH-1:0] SKP_RDN = 10'h0F9,
    parameter logic [DATA_WIDTH-1:0] SKP_RDP = 10'h306
) (
    input  logic                              read_clk,
    input  logic                              rst_n,
    input  logic                              buffer_mode,
    input  logic [$clog2(BUFFER_DEPTH):0]     fill_level,
    input  logic [DATA_WIDTH-1:0]             rd_symbol,
    output logic [1:0]                        rd_inc,
    output logic                              data_valid,
    output logic                              skp_added,
    output logic                              skp_removed,
    output logic                              overflow,
    output logic                              underflow
`ifdef EB_SKP_STATS_EN
    ,
    output logic [7:0]                        add_cnt,
    output logic [7:0]                        rem_cnt
`endif
);

    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int TW = AW + 3;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(BUFFER_DEPTH);
    localparam logic [AW:0] MIN_REM  = (AW+1)'(2);

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    state_t state, state_nxt;
    logic   os_adj, os_adj_nxt;

    logic signed [TW-1:0] fill_s, tgt_s, hi_s, lo_s;
    logic is_skp, empty, full, adj_ok, do_rem, do_add;

    // Thresholds are signed so a target inside the dead band never triggers an insert.
    assign fill_s = $signed({2'b00, fill_level});
    assign tgt_s  = buffer_mode ? TW'(BUFFER_DEPTH / 2) : TW'(LOW_TARGET);
    assign hi_s   = tgt_s + TW'(HYST);
    assign lo_s   = tgt_s - TW'(HYST);

    assign is_skp = (rd_symbol == SKP_RDN) || (rd_symbol == SKP_RDP);
    assign empty  = (fill_level == '0);
    assign full   = (fill_level >= FULL_LVL);
    assign adj_ok = (state == RUN) && !empty && !full && is_skp && !os_adj;
    assign do_rem = adj_ok && (fill_s > hi_s) && (fill_level >= MIN_REM);
    assign do_add = adj_ok && !do_rem && (fill_s < lo_s);

    always_ff @(posedge read_clk) begin
        if (!rst_n) begin
            state  <= FILL;
            os_adj <= 1'b0;
        end else begin
            state  <= state_nxt;
            os_adj <= os_adj_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        os_adj_nxt = os_adj;
        case (state)
            FILL: begin
                if (fill_s >= tgt_s)
                    state_nxt = RUN;
            end
            RUN: begin
                if (empty)
                    state_nxt = FILL;
                else if (do_rem || do_add)
                    os_adj_nxt = 1'b1;
                else if (data_valid && !is_skp)
                    os_adj_nxt = 1'b0;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        rd_inc      = 2'd0;
        data_valid  = 1'b0;
        skp_added   = 1'b0;
        skp_removed = 1'b0;
        overflow    = 1'b0;
        underflow   = 1'b0;
        if (state == RUN) begin
            if (empty) begin
                underflow = 1'b1;
            end else if (full) begin
                overflow   = 1'b1;
                rd_inc     = 2'd1;
                data_valid = 1'b1;
            end else if (do_rem) begin
                rd_inc      = 2'd2;
                skp_removed = 1'b1;
                data_valid  = 1'b1;
            end else if (do_add) begin
                // Hold the pointer so the same SKP is presented again.
                skp_added  = 1'b1;
                data_valid = 1'b1;
            end else begin
                rd_inc     = 2'd1;
                data_valid = 1'b1;
            end
        end
    end

`ifdef EB_SKP_STATS_EN
    always_ff @(posedge read_clk) begin
        if (!rst_n) begin
            add_cnt <= 8'd0;
            rem_cnt <= 8'd0;
        end else begin
            if (skp_added && add_cnt != 8'hFF)
                add_cnt <= add_cnt + 8'd1;
            if (skp_removed && rem_cnt != 8'hFF)
                rem_cnt <= rem_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eb_skp_ctrl.sv
// tb/tb_eb_skp_ctrl.sv - scoreboard bench for eb_skp_ctrl
module tb_eb_skp_ctrl;

    logic       read_clk = 1'b0;
    logic       rst_n;
    logic       buffer_mode;
    logic [4:0] fill_level;
    logic [9:0] rd_symbol;
    logic [1:0] rd_inc;
    logic       data_valid, skp_added, skp_removed, overflow, underflow;
`ifdef EB_SKP_STATS_EN
    logic [7:0] add_cnt, rem_cnt;
`endif

    eb_skp_ctrl dut (
        .read_clk    (read_clk),
        .rst_n       (rst_n),
        .buffer_mode (buffer_mode),
        .fill_level  (fill_level),
        .rd_symbol   (rd_symbol),
        .rd_inc      (rd_inc),
        .data_valid  (data_valid),
        .skp_added   (skp_added),
        .skp_removed (skp_removed),
        .overflow    (overflow),
        .underflow   (underflow)
`ifdef EB_SKP_STATS_EN
        ,
        .add_cnt     (add_cnt),
        .rem_cnt     (rem_cnt)
`endif
    );

    always #5 read_clk = ~read_clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] exp_q[$];

    // {rd_inc, data_valid, skp_added, skp_removed, overflow, underflow}
    localparam logic [6:0] IDLE = 7'b00_0_0_0_0_0;
    localparam logic [6:0] NORM = 7'b01_1_0_0_0_0;
    localparam logic [6:0] REMV = 7'b10_1_0_1_0_0;
    localparam logic [6:0] ADDS = 7'b00_1_1_0_0_0;
    localparam logic [6:0] OVFL = 7'b01_1_0_0_1_0;
    localparam logic [6:0] UNFL = 7'b00_0_0_0_0_1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit rstn, input bit mode, input int fill, input logic [9:0] sym,
                         input bit do_chk, input logic [6:0] exp, input string tag);
        logic [6:0] e;
        @(negedge read_clk);
        rst_n       = rstn;
        buffer_mode = mode;
        fill_level  = 5'(fill);
        rd_symbol   = sym;
        if (do_chk) exp_q.push_back(exp);
        #1;
        if (do_chk) begin
            e = exp_q.pop_front();
            check(tag, 32'({rd_inc, data_valid, skp_added, skp_removed, overflow, underflow}), 32'(e));
        end
    endtask

    // Reference behaviour written from the block description, used for random traffic.
    bit m_run, m_adj;
    function automatic logic [6:0] model_out(input bit run, input bit adj, input bit mode,
                                             input int fill, input logic [9:0] sym);
        int  t;
        bit  skp;
        t   = mode ? 8 : 2;
        skp = (sym == 10'h0F9) || (sym == 10'h306);
        if (!run)                                     return IDLE;
        if (fill == 0)                                return UNFL;
        if (fill >= 16)                               return OVFL;
        if (skp && !adj && fill > t + 1 && fill >= 2) return REMV;
        if (skp && !adj && fill < t - 1)              return ADDS;
        return NORM;
    endfunction

    initial begin
        rst_n = 1'b0; buffer_mode = 1'b0; fill_level = '0; rd_symbol = '0;

        drive(0, 0, 0, 10'h17C, 0, IDLE, "rst0");
        drive(0, 0, 0, 10'h17C, 1, IDLE, "rst1");
        drive(1, 0, 0, 10'h17C, 1, IDLE, "fill0");
        drive(1, 0, 1, 10'h17C, 1, IDLE, "fill1");
        drive(1, 0, 2, 10'h17C, 1, IDLE, "fill2");
        drive(1, 0, 2, 10'h17C, 1, NORM, "run_first");

        drive(1, 0, 5, 10'h17C, 1, NORM, "rem_pre");
        drive(1, 0, 5, 10'h0F9, 1, REMV, "rem_skp1");
        drive(1, 0, 5, 10'h0F9, 1, NORM, "rem_skp2");
        drive(1, 0, 5, 10'h0AA, 1, NORM, "rem_post");

        drive(1, 1, 5, 10'h306, 1, ADDS, "ins_skp1");
        drive(1, 1, 5, 10'h306, 1, NORM, "ins_skp2");
        drive(1, 1, 5, 10'h2BB, 1, NORM, "ins_post");
        drive(1, 1, 5, 10'h306, 1, ADDS, "ins_again");
        drive(1, 1, 5, 10'h2BB, 1, NORM, "ins_post2");

        drive(1, 1, 0, 10'h2BB, 1, UNFL, "unf");
        drive(1, 0, 1, 10'h2BB, 1, IDLE, "unf_fill1");
        drive(1, 0, 2, 10'h2BB, 1, IDLE, "unf_fill2");
        drive(1, 0, 2, 10'h2BB, 1, NORM, "unf_run");

        drive(1, 0, 16, 10'h0F9, 1, OVFL, "ovf_skp");
        drive(1, 0, 20, 10'h2BB, 1, OVFL, "ovf_above");
        drive(1, 1, 8, 10'h0F9, 1, NORM, "mode_dead");
        drive(1, 0, 8, 10'h0F9, 1, REMV, "mode_switch");
        drive(1, 0, 8, 10'h2BB, 1, NORM, "mode_post");

        drive(0, 1, 5, 10'h306, 0, IDLE, "midrst");
        drive(1, 1, 5, 10'h306, 1, IDLE, "midrst_after");
        drive(1, 1, 8, 10'h2BB, 1, IDLE, "midrst_fill");
        drive(1, 1, 8, 10'h2BB, 1, NORM, "midrst_run");

        for (int i = 0; i < 300; i++) begin
            drive(1, 0, 5, 10'h0F9, (i % 50) == 0, REMV, "sat_rem");
            drive(1, 0, 5, 10'h2BB, (i % 50) == 0, NORM, "sat_clr");
        end
`ifdef EB_SKP_STATS_EN
        check("rem_cnt_sat", 32'(rem_cnt), 32'd255);
        check("add_cnt", 32'(add_cnt), 32'd0);
`endif

        drive(0, 0, 0, 10'h000, 0, IDLE, "rnd_rst");
        m_run = 0; m_adj = 0;
        for (int i = 0; i < 400; i++) begin
            bit         rstn, mode;
            int         fill;
            logic [9:0] sym;
            logic [6:0] e;
            int         t;
            rstn = ($urandom_range(0, 49) != 0);
            mode = 1'($urandom_range(0, 1));
            fill = $urandom_range(0, 20);
            case ($urandom_range(0, 3))
                0:       sym = 10'h0F9;
                1:       sym = 10'h306;
                default: sym = 10'($urandom);
            endcase
            e = model_out(m_run, m_adj, mode, fill, sym);
            drive(rstn, mode, fill, sym, 1, e, "rnd");
            t = mode ? 8 : 2;
            if (!rstn) begin
                m_run = 0; m_adj = 0;
            end else if (!m_run) begin
                m_run = (fill >= t);
            end else if (fill == 0) begin
                m_run = 0;
            end else if (e == REMV || e == ADDS) begin
                m_adj = 1;
            end else if (e[4] && !(sym == 10'h0F9 || sym == 10'h306)) begin
                m_adj = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
